binary_expander: RTL and testbench
==================================

// Module: binary_expander
// PURPOSE
//  Inverse of the output thresholding stage. Takes a packed word of binary pixels or flags and emits
//  it serially as Q(DWIDTH-frac).frac fixed-point samples (1.0 or 0.0), one per handshake.
//  Sits between the binarised image buffer and the NN input-layer MAC feed.
// PARAMETERS
//  DWIDTH     32  width of each emitted fixed-point sample
//  frac       24  fractional bits; a "1" bit is emitted as 1<<frac (32'h0100_0000)
//  NBITS      16  binary bits per input word (>=2)
//  MSB_FIRST  0   0: emit in_word[0] first; 1: emit in_word[NBITS-1] first
// PORTS
//  clk       in   1                 rising-edge clock
//  reset     in   1                 asynchronous, active-low reset
//  en        in   1                 global enable/stall; 0 freezes all state
//  in_word   in   NBITS             packed binary input word
//  in_valid  in   1                 in_word is valid
//  in_ready  out  1                 block can accept in_word
//  out_data  out  DWIDTH            fixed-point sample: 1<<frac or 0
//  out_idx   out  $clog2(NBITS)     bit position in in_word of the current sample
//  out_valid out  1                 out_data, out_idx and out_last are valid
//  out_ready in   1                 consumer accepts the sample
//  out_last  out  1                 current sample is the final bit of the word
// BEHAVIOUR
//  - Reset (reset=0, async) forces state=IDLE, shreg=0, cnt=0, out_data=0, out_valid=0, out_last=0,
//    out_idx=0, and in_ready=0 while reset is held.
//  - FSM states: IDLE, EMIT.
//  - IDLE: in_ready = en. On rising clk with en & in_valid & in_ready:
//    shreg<=in_word, cnt<=0, go to EMIT. in_ready=0 in EMIT.
//  - EMIT: out_valid = en. Let cur = MSB_FIRST ? shreg[NBITS-1] : shreg[0].
//    out_data = cur ? (1<<frac) : 0. Upper bits are always 0.
//    out_idx = MSB_FIRST ? NBITS-1-cnt : cnt. out_last = (cnt==NBITS-1).
//  - Beat completes on en & out_valid & out_ready: shreg shifts toward the emit end with a zero fill,
//    and cnt increments. If the beat is the last beat, go to IDLE and cnt<=0.
//  - out_valid=0 and out_ready=1 (or the reverse): no state change. out_data, out_idx and out_last
//    stay stable while out_valid=1 and the sample is not accepted.
//  - en=0: no transfers in either direction. in_ready=0 and out_valid=0. shreg, cnt and state hold.
//    Output resumes with the same sample when en returns to 1.
//  - Throughput: NBITS+1 cycles per word at full rate (1 accept cycle + NBITS emit cycles).
//    There is no overlap of accept and emit.
//  - in_valid is ignored outside IDLE. The word is latched, so in_word may change after the accept.
//  - out_* depend only on registers and en. There is no combinational path from in_* or out_ready.
//  - Reset asserted mid-word: the word in flight is discarded. After release the FSM is in IDLE
//    with in_ready=1 when en=1.
// TESTING
//  1. Reset release, en=1, idle -> out_valid=0, in_ready=1, out_data=0.
//  2. NBITS=16, MSB_FIRST=0, in_word=16'hA5C3, out_ready=1 -> 16 beats, out_data sequence
//     1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (1 = 32'h0100_0000, 0 = 32'h0).
//     out_idx runs 0..15. out_last=1 only on beat 16. in_ready returns to 1 on the next cycle.
//  3. Same word with MSB_FIRST=1 -> sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. out_idx runs 15..0.
//  4. Backpressure: out_ready=0 for 5 cycles at beat 3 -> out_data and out_idx=2 held stable.
//     No beat is lost or duplicated.
//  5. en=0 for 4 cycles mid-word -> out_valid=0, in_ready=0. The same sample reappears when en=1.
//     Total beats = 16.
//  6. Reset pulse at beat 7 -> all outputs 0 immediately. A new word 16'hFFFF then yields
//     16 samples of 32'h0100_0000.

Source files
------------

// File: rtl/binary_expander.sv
// rtl/binary_expander.sv - serialises a packed binary word into fixed-point 1.0/0.0 samples
module binary_expander #(
  parameter int DWIDTH    = 32,
  parameter int frac      = 24,
  parameter int NBITS     = 16,
  parameter int MSB_FIRST = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NBITS-1:0]         in_word,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DWIDTH-1:0]        out_data,
  output logic [$clog2(NBITS)-1:0] out_idx,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int IW = $clog2(NBITS);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;
  localparam logic [IW-1:0]     LAST_CNT = IW'(NBITS - 1);
  localparam logic [DWIDTH-1:0] ONE      = DWIDTH'(1) << frac;

  logic [0:0]       state;
  logic [NBITS-1:0] shreg;
  logic [IW-1:0]    cnt;
  logic             emit;
  logic             cur;
  logic             accept;
  logic             beat;

  assign emit = (state == EMIT);
  assign cur  = (MSB_FIRST != 0) ? shreg[NBITS-1] : shreg[0];

  // in_ready is gated by reset so it reads 0 while reset is held
  assign in_ready  = reset & en & ~emit;
  assign out_valid = en & emit;
  assign out_data  = (emit & cur) ? ONE : '0;
  assign out_idx   = emit ? ((MSB_FIRST != 0) ? (LAST_CNT - cnt) : cnt) : '0;
  assign out_last  = emit & (cnt == LAST_CNT);

  assign accept = in_ready & in_valid;
  assign beat   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= in_word;
      cnt   <= '0;
      state <= EMIT;
    end else if (beat) begin
      shreg <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
      if (cnt == LAST_CNT) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_binary_expander.sv
// tb/tb_binary_expander.sv - bench for binary_expander, LSB-first and MSB-first instances side by side
module tb_binary_expander;

  localparam logic [31:0] ONE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [15:0] in_word = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready_l, out_valid_l, out_last_l;
  logic [31:0] out_data_l;
  logic [3:0]  out_idx_l;
  logic        in_ready_m, out_valid_m, out_last_m;
  logic [31:0] out_data_m;
  logic [3:0]  out_idx_m;

  int checks = 0;
  int errors = 0;

  // model of the word in flight
  bit        busy = 1'b0;
  bit [15:0] word = '0;
  int        k = 0;

  // what the DUTs actually delivered
  int          nbeats = 0;
  logic [15:0] seq_l = '0;
  logic [15:0] seq_m = '0;

  binary_expander #(.DWIDTH(32), .frac(24), .NBITS(16), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(rst_n), .en(en), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_data(out_data_l), .out_idx(out_idx_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l)
  );

  binary_expander #(.DWIDTH(32), .frac(24), .NBITS(16), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(rst_n), .en(en), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_data(out_data_m), .out_idx(out_idx_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0;
      k = 0;
    end else if (en) begin
      if (!busy) begin
        if (in_valid) begin
          busy = 1'b1;
          word = in_word;
          k = 0;
        end
      end else if (out_ready) begin
        if (k == 15) busy = 1'b0;
        else k++;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && en && out_valid_l && out_ready) begin
      nbeats++;
      seq_l = {out_data_l == ONE, seq_l[15:1]};
      seq_m = {seq_m[14:0], out_data_m == ONE};
    end
  end

  always @(negedge clk) begin
    logic exp_ir, exp_ov;
    exp_ir = rst_n && en && !busy;
    exp_ov = rst_n && en && busy;
    chk("in_ready_l", 32'(in_ready_l), 32'(exp_ir));
    chk("in_ready_m", 32'(in_ready_m), 32'(exp_ir));
    chk("out_valid_l", 32'(out_valid_l), 32'(exp_ov));
    chk("out_valid_m", 32'(out_valid_m), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_data_l", out_data_l, word[k] ? ONE : 32'h0);
      chk("out_idx_l", 32'(out_idx_l), 32'(k));
      chk("out_last_l", 32'(out_last_l), 32'(k == 15));
      chk("out_data_m", out_data_m, word[15-k] ? ONE : 32'h0);
      chk("out_idx_m", 32'(out_idx_m), 32'(15 - k));
      chk("out_last_m", 32'(out_last_m), 32'(k == 15));
    end else if (!busy) begin
      chk("idle_data_l", out_data_l, 32'h0);
      chk("idle_data_m", out_data_m, 32'h0);
      chk("idle_last_l", 32'(out_last_l), 32'h0);
    end
  end

  task automatic start_word(input logic [15:0] w);
    nbeats = 0;
    seq_l = '0;
    seq_m = '0;
    in_word = w;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    in_word = 16'($urandom);
  endtask

  initial begin
    #1;
    chk("reset_in_ready", 32'(in_ready_l), 32'h0);
    chk("reset_out_valid", 32'(out_valid_l), 32'h0);
    chk("reset_out_idx_m", 32'(out_idx_m), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_in_ready", 32'(in_ready_l), 32'h1);
    chk("idle_out_valid", 32'(out_valid_l), 32'h0);
    chk("idle_out_data", out_data_l, 32'h0);

    // full-rate word, both bit orders
    start_word(16'hA5C3);
    repeat (16) cyc();
    chk("lsb_sequence", 32'(seq_l), 32'h0000_A5C3);
    chk("msb_sequence", 32'(seq_m), 32'h0000_A5C3);
    chk("full_rate_beats", 32'(nbeats), 32'd16);
    chk("in_ready_after_word", 32'(in_ready_l), 32'h1);

    // backpressure on beat 3
    start_word(16'hA5C3);
    repeat (2) cyc();
    out_ready = 1'b0;
    chk("bp_idx_l", 32'(out_idx_l), 32'd2);
    chk("bp_data_l", out_data_l, 32'h0);
    chk("bp_idx_m", 32'(out_idx_m), 32'd13);
    repeat (5) cyc();
    chk("bp_idx_hold", 32'(out_idx_l), 32'd2);
    out_ready = 1'b1;
    repeat (14) cyc();
    chk("bp_beats", 32'(nbeats), 32'd16);
    chk("bp_sequence", 32'(seq_l), 32'h0000_A5C3);

    // stall with en=0 mid-word
    start_word(16'h3C96);
    repeat (4) cyc();
    en = 1'b0;
    #1;
    chk("stall_out_valid", 32'(out_valid_l), 32'h0);
    chk("stall_in_ready", 32'(in_ready_l), 32'h0);
    repeat (4) cyc();
    en = 1'b1;
    #1;
    chk("resume_idx", 32'(out_idx_l), 32'd4);
    repeat (12) cyc();
    chk("stall_beats", 32'(nbeats), 32'd16);
    chk("stall_sequence", 32'(seq_l), 32'h0000_3C96);

    // reset mid-word, then an all-ones word
    start_word(16'h1234);
    repeat (6) cyc();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid_l), 32'h0);
    chk("rst_out_data", out_data_l, 32'h0);
    chk("rst_out_idx", 32'(out_idx_m), 32'h0);
    chk("rst_out_last", 32'(out_last_l), 32'h0);
    chk("rst_in_ready", 32'(in_ready_l), 32'h0);
    cyc();
    rst_n = 1'b1;
    start_word(16'hFFFF);
    repeat (16) cyc();
    chk("ones_beats", 32'(nbeats), 32'd16);
    chk("ones_sequence_l", 32'(seq_l), 32'h0000_FFFF);
    chk("ones_sequence_m", 32'(seq_m), 32'h0000_FFFF);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = $urandom_range(0, 1);
      in_word   = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 599) != 0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
